// File: rtl/sqr.sv
// Iterative shift-and-add squarer: rad = (root*root >> FBITS) + rem, one multiplier bit per clock.
// Optional build macro SQR_ROUND_EN rounds the scaled product to nearest before rem is added.
module sqr #(
    parameter int WIDTH = 8,
    parameter int FBITS = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             valid,
    input  logic [WIDTH-1:0] root,
    input  logic [WIDTH-1:0] rem,
    output logic [WIDTH-1:0] rad,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam int PW = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SQR_ROUND_EN
    localparam int RBIT = (FBITS > 0) ? (FBITS - 1) : 0;
    localparam logic [PW:0] RND = (FBITS > 0) ? ((PW+1)'(1) << RBIT) : '0;
`else
    localparam logic [PW:0] RND = '0;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t state_r;
    state_t state_nx_s;

    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplr_r;
    logic [PW-1:0]    acc_r;
    logic [CW-1:0]    i_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] rad_r;
    logic             ovf_r;
    logic             valid_r;

    logic             last_s;
    logic             load_s;
    logic             step_s;
    logic             done_s;
    logic [PW-1:0]    pp_s;
    logic [PW-1:0]    prod_s;
    logic [PW:0]      rnd_s;
    logic [PW:0]      scaled_s;
    logic [PW:0]      tot_s;
    logic             ovf_s;

    assign last_s = (i_r == LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; a start in any state (re)enters CALC
    always_comb begin
        state_nx_s = state_r;
        if (start) begin
            state_nx_s = CALC;
        end else begin
            case (state_r)
                IDLE:    state_nx_s = IDLE;
                CALC:    state_nx_s = last_s ? IDLE : CALC;
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // Control decode from current state
    always_comb begin
        load_s = 1'b0;
        step_s = 1'b0;
        done_s = 1'b0;
        if (start) begin
            load_s = 1'b1;
        end else if (state_r == CALC) begin
            step_s = 1'b1;
            done_s = last_s;
        end else begin
            step_s = 1'b0;
        end
    end

    // Datapath: last partial product folds in combinationally so the result lands on the final edge
    always_comb begin
        pp_s = '0;
        if (mplr_r[0]) begin
            pp_s = {{WIDTH{1'b0}}, mcand_r} << i_r;
        end else begin
            pp_s = '0;
        end
        prod_s   = acc_r + pp_s;
        rnd_s    = {1'b0, prod_s} + RND;
        scaled_s = rnd_s >> FBITS;
        tot_s    = scaled_s + {{(PW + 1 - WIDTH){1'b0}}, rem_r};
    end

    assign ovf_s = |tot_s[PW:WIDTH];

    // Operand, accumulator and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r <= '0;
            mplr_r  <= '0;
            acc_r   <= '0;
            i_r     <= '0;
            rem_r   <= '0;
            rad_r   <= '0;
            ovf_r   <= 1'b0;
            valid_r <= 1'b0;
        end else if (load_s) begin
            mcand_r <= root;
            mplr_r  <= root;
            acc_r   <= '0;
            i_r     <= '0;
            rem_r   <= rem;
            valid_r <= 1'b0;
        end else if (step_s) begin
            acc_r  <= prod_s;
            mplr_r <= mplr_r >> 1;
            i_r    <= i_r + CW'(1);
            if (done_s) begin
                rad_r   <= tot_s[WIDTH-1:0];
                ovf_r   <= ovf_s;
                valid_r <= 1'b1;
            end else begin
                valid_r <= valid_r;
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    assign busy  = (state_r == CALC);
    assign valid = valid_r;
    assign rad   = rad_r;
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_sqr.sv
// Self-checking bench for sqr: integer instance (FBITS=0) and fixed-point instance (FBITS=4),
// compared against an arithmetic reference model.
module tb_sqr;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start_a, start_b;
    logic         busy_a, busy_b;
    logic         valid_a, valid_b;
    logic [W-1:0] root_a, root_b;
    logic [W-1:0] rem_a, rem_b;
    logic [W-1:0] rad_a, rad_b;
    logic         ovf_a, ovf_b;

    int n_vec;
    int n_bad;

    sqr #(.WIDTH(W), .FBITS(0)) u_int (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .valid(valid_a),
        .root(root_a), .rem(rem_a), .rad(rad_a), .ovf(ovf_a)
    );

    sqr #(.WIDTH(W), .FBITS(4)) u_fix (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .valid(valid_b),
        .root(root_b), .rem(rem_b), .rad(rad_b), .ovf(ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: square, scale (optionally rounded), add remainder, split into low bits and overflow
    function automatic logic [W:0] model(input int r, input int m, input int fb);
        longint p;
        longint t;
        p = longint'(r) * longint'(r);
`ifdef SQR_ROUND_EN
        if (fb > 0) p = p + (longint'(1) << (fb - 1));
`endif
        t = (p >> fb) + longint'(m);
        model = {(t >= 256), t[W-1:0]};
    endfunction

    function automatic logic get_valid(input int w);
        return (w != 0) ? valid_b : valid_a;
    endfunction

    function automatic logic get_busy(input int w);
        return (w != 0) ? busy_b : busy_a;
    endfunction

    task automatic do_op(input int w, input logic [W-1:0] r, input logic [W-1:0] m,
                         output logic [W-1:0] rad_o, output logic ovf_o,
                         output int lat, output int busy_cnt, output logic busy_end);
        @(negedge clk);
        if (w != 0) begin start_b = 1'b1; root_b = r; rem_b = m; end
        else        begin start_a = 1'b1; root_a = r; rem_a = m; end
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        root_a = W'($urandom); rem_a = W'($urandom);
        root_b = W'($urandom); rem_b = W'($urandom);
        busy_cnt = get_busy(w) ? 1 : 0;
        lat = -1;
        busy_end = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (get_valid(w)) begin
                lat = k;
                busy_end = get_busy(w);
                break;
            end
            if (get_busy(w)) busy_cnt++;
        end
        rad_o = (w != 0) ? rad_b : rad_a;
        ovf_o = (w != 0) ? ovf_b : ovf_a;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        root_a = '0; rem_a = '0; root_b = '0; rem_b = '0;
        #23;
        n_vec++;
        if ({busy_a, valid_a, rad_a, ovf_a, busy_b, valid_b, rad_b, ovf_b} !== '0) begin
            n_bad++;
            $display("FAIL reset: busy=%b/%b valid=%b/%b rad=%0d/%0d ovf=%b/%b, required all 0",
                     busy_a, busy_b, valid_a, valid_b, rad_a, rad_b, ovf_a, ovf_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [W-1:0] rd; logic ov; int lat; int bc; logic be;
        do_op(0, 8'd15, 8'd6, rd, ov, lat, bc, be);
        n_vec++;
        if ({rd, ov} !== {8'd231, 1'b0}) begin
            n_bad++; $display("FAIL basic: rad=%0d ovf=%b, required rad=231 ovf=0", rd, ov);
        end
        n_vec++;
        if (lat !== 8) begin
            n_bad++; $display("FAIL basic_latency: %0d edges, required 8", lat);
        end
        n_vec++;
        if (bc !== 8 || be !== 1'b0) begin
            n_bad++; $display("FAIL basic_busy: high %0d cycles end=%b, required 8 cycles end=0", bc, be);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] rd; logic ov; int lat; int bc; logic be;
        do_op(0, 8'd16, 8'd0, rd, ov, lat, bc, be);
        n_vec++;
        if ({rd, ov} !== {8'd0, 1'b1}) begin
            n_bad++; $display("FAIL ovf_16: rad=%0d ovf=%b, required rad=0 ovf=1", rd, ov);
        end
        do_op(0, 8'd15, 8'd31, rd, ov, lat, bc, be);
        n_vec++;
        if ({rd, ov} !== {8'd0, 1'b1}) begin
            n_bad++; $display("FAIL ovf_rem: rad=%0d ovf=%b, required rad=0 ovf=1", rd, ov);
        end
    endtask

    task automatic test_fixed();
        logic [W-1:0] rd; logic ov; int lat; int bc; logic be;
        logic [W-1:0] exp_1b;
`ifdef SQR_ROUND_EN
        exp_1b = 8'h2E;
`else
        exp_1b = 8'h2D;
`endif
        do_op(1, 8'h18, 8'h00, rd, ov, lat, bc, be);
        n_vec++;
        if ({rd, ov} !== {8'h24, 1'b0}) begin
            n_bad++; $display("FAIL fix_1p5: rad=%h ovf=%b, required rad=24 ovf=0", rd, ov);
        end
        n_vec++;
        if (lat !== 8) begin
            n_bad++; $display("FAIL fix_latency: %0d edges, required 8", lat);
        end
        do_op(1, 8'h1B, 8'h00, rd, ov, lat, bc, be);
        n_vec++;
        if ({rd, ov} !== {exp_1b, 1'b0}) begin
            n_bad++; $display("FAIL fix_1b: rad=%h ovf=%b, required rad=%h ovf=0", rd, ov, exp_1b);
        end
    endtask

    task automatic test_zero_max();
        logic [W-1:0] rd; logic ov; int lat; int bc; logic be;
        do_op(0, 8'd0, 8'd0, rd, ov, lat, bc, be);
        n_vec++;
        if ({rd, ov} !== {8'd0, 1'b0}) begin
            n_bad++; $display("FAIL zero: rad=%0d ovf=%b, required rad=0 ovf=0", rd, ov);
        end
        do_op(0, 8'hFF, 8'd0, rd, ov, lat, bc, be);
        n_vec++;
        if ({rd, ov} !== {8'd1, 1'b1}) begin
            n_bad++; $display("FAIL max: rad=%0d ovf=%b, required rad=1 ovf=1", rd, ov);
        end
    endtask

    task automatic test_restart();
        int lat;
        int early;
        early = 0;
        @(negedge clk);
        start_a = 1'b1; root_a = 8'd15; rem_a = 8'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (valid_a) early++;
        end
        start_a = 1'b1; root_a = 8'd3; rem_a = 8'd1;
        @(negedge clk);
        start_a = 1'b0; root_a = 8'd15; rem_a = 8'd0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (valid_a) begin lat = k; break; end
        end
        n_vec++;
        if (early !== 0 || lat !== 8) begin
            n_bad++; $display("FAIL restart_timing: early_valid=%0d latency=%0d, required 0 and 8", early, lat);
        end
        n_vec++;
        if ({rad_a, ovf_a} !== {8'd10, 1'b0}) begin
            n_bad++; $display("FAIL restart_value: rad=%0d ovf=%b, required rad=10 ovf=0", rad_a, ovf_a);
        end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] rd; logic ov; int lat; int bc; logic be;
        int seen;
        do_op(0, 8'd9, 8'd0, rd, ov, lat, bc, be);
        @(negedge clk);
        start_a = 1'b1; root_a = 8'd15; rem_a = 8'd0;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy_a, valid_a, rad_a, ovf_a} !== '0) begin
            n_bad++;
            $display("FAIL reset_midop: busy=%b valid=%b rad=%0d ovf=%b, required all 0",
                     busy_a, valid_a, rad_a, ovf_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (valid_a || busy_a) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_bad++; $display("FAIL reset_idle: valid/busy seen %0d times, required 0", seen);
        end
        do_op(0, 8'd7, 8'd0, rd, ov, lat, bc, be);
        n_vec++;
        if ({rd, ov} !== {8'd49, 1'b0} || lat !== 8) begin
            n_bad++; $display("FAIL reset_after: rad=%0d ovf=%b lat=%0d, required rad=49 ovf=0 lat=8", rd, ov, lat);
        end
    endtask

    task automatic test_hold();
        int bad;
        logic [W-1:0] rd; logic ov; int lat; int bc; logic be;
        do_op(0, 8'd12, 8'd5, rd, ov, lat, bc, be);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            root_a = W'($urandom); rem_a = W'($urandom);
            if ({valid_a, busy_a, rad_a, ovf_a} !== {1'b1, 1'b0, 8'd149, 1'b0}) bad++;
        end
        n_vec++;
        if (bad !== 0) begin
            n_bad++; $display("FAIL hold: %0d cycles lost result, required rad=149 held", bad);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] rd; logic ov; int lat; int bc; logic be;
        logic [W:0] exp_v;
        int r; int m; int w;
        for (int n = 0; n < 60; n++) begin
            w = n % 2;
            r = $urandom_range(255, 0);
            m = (n % 3 == 0) ? $urandom_range(255, 0) : $urandom_range(15, 0);
            exp_v = model(r, m, (w != 0) ? 4 : 0);
            do_op(w, W'(r), W'(m), rd, ov, lat, bc, be);
            n_vec++;
            if ({ov, rd} !== exp_v || lat !== 8) begin
                n_bad++;
                $display("FAIL random: dut=%0d root=%0d rem=%0d got rad=%0d ovf=%b lat=%0d, required rad=%0d ovf=%b lat=8",
                         w, r, m, rd, ov, lat, exp_v[W-1:0], exp_v[W]);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_fixed();
        test_zero_max();
        test_restart();
        test_reset_midop();
        test_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sqr.md
Name: sqr

Overview:
- Iterative fixed-point squarer. The inverse companion of the team's iterative square-root unit.
- Given a root and a remainder, it reconstructs the radicand: rad = (root*root >> FBITS) + rem.
- It uses a shift-and-add multiplier that consumes one multiplier bit per clock.
- Used in self-check paths and test harnesses to confirm sqrt results. Also used standalone wherever a low-area square is needed.

Parameters:
- WIDTH, 8: width of root, rem and rad. Must be ≥2.
- FBITS, 0: fractional bits of the fixed-point format. Must satisfy 0 ≤ FBITS < WIDTH.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active-low
- start  input  1  start signal; samples root and rem
- busy  output  1  calculation in progress
- valid  output  1  rad and ovf are valid
- root  input  WIDTH  root operand, unsigned fixed point
- rem  input  WIDTH  remainder to add after squaring, same format as rad
- rad  output  WIDTH  reconstructed radicand
- ovf  output  1  result did not fit in WIDTH bits

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (rst_n).
  - While rst_n=0: busy=0, valid=0, rad=0, ovf=0.
  - Internal state is cleared: multiplicand, multiplier, accumulator (2*WIDTH bits) and iteration counter i.
  - Reset asserted mid-operation aborts immediately; there is no result.
- States:
  - IDLE (busy=0) and CALC (busy=1). valid is a separate sticky flag.
- start sampled high (in any state, including CALC):
  - load mcand=root, mplr=root, acc=0, i=0; latch rem.
  - busy←1, valid←0.
  - start while busy restarts with the new operands; the old result is discarded.
- CALC, each cycle:
  - if mplr[0]=1 then acc←acc + (mcand << i).
  - mplr←mplr>>1, i←i+1.
  - Counter width is $clog2(WIDTH).
- Final iteration (i==WIDTH-1):
  - p = final 2*WIDTH-bit product, with the last partial product included combinationally.
  - s = p >> FBITS, truncated.
  - t = s + rem, computed at 2*WIDTH+1 bits.
  - rad←t[WIDTH-1:0].
  - ovf←1 if any bit of t above WIDTH-1 is set.
  - busy←0, valid←1.
- Latency: valid rises exactly WIDTH clock edges after the edge that sampled start.
- Result hold: valid, rad and ovf hold until the next start or reset. Operand inputs may change freely after the start edge.
- start is ignored only while rst_n=0.
- Arithmetic: all unsigned, no saturation. On overflow, rad carries the wrapped low WIDTH bits.

Optional Feature:
- Macro: SQR_ROUND_EN.
- Defined:
  - Before adding rem, s is rounded to nearest: s = (p + (1 << (FBITS-1))) >> FBITS, with half rounding up.
  - A carry out of the rounding add contributes to ovf.
  - When FBITS=0, no rounding is applied.
- Undefined: truncation as described in Behaviour.
- Latency is identical in both builds.

Test Plan:
- Basic square, WIDTH=8 FBITS=0: root=15, rem=6 -> after 8 cycles valid=1, rad=231, ovf=0. busy high for exactly 8 cycles.
- Overflow, WIDTH=8 FBITS=0: root=16, rem=0 -> rad=0, ovf=1. Also root=15, rem=31 -> t=256, rad=0, ovf=1.
- Fixed point, WIDTH=8 FBITS=4:
  - root=0x18 (1.5) -> rad=0x24 (2.25), ovf=0.
  - root=0x1B -> rad=0x2D truncated; 0x2E with SQR_ROUND_EN.
- Zero and max: root=0, rem=0 -> rad=0, ovf=0. WIDTH=8 root=0xFF -> ovf=1.
- Restart mid-operation: start root=15 rem=0, then start again on cycle 3 with root=3 rem=1.
  - Required: valid stays 0 until 8 cycles after the second start, then rad=10.
  - At no point does valid assert with 225.
- Reset mid-operation:
  - Drop rst_n asynchronously on cycle 4 of a calculation -> busy=0, valid=0, rad=0 immediately.
  - After release with no start, valid stays 0.
  - A following start root=7 rem=0 -> rad=49.
